// File: rtl/pdm_adc.sv
// rtl/pdm_adc.sv - Stereo 1-bit sigma-delta capture: modulator clock, sync, 3rd-order CIC decimator, PCM handshake.
module pdm_adc #(
  parameter int DIV_LOG2 = 5,
  parameter int DEC_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pdm_L,
  input  logic        pdm_R,
  input  logic        rd_ack,
  output logic        mod_clk,
  output logic [15:0] adc_L,
  output logic [15:0] adc_R,
  output logic        adc_valid,
  output logic        adc_overrun
);

  localparam int W = 3 * DEC_LOG2 + 1;

  // Full scale (U == 2^(W-1)) saturates; otherwise take the top 16 magnitude bits and flip to signed.
  function automatic logic [15:0] to_pcm(input logic [W-1:0] u);
    logic [15:0] u16;
    u16 = u[W-1] ? 16'hFFFF : u[W-2 -: 16];
    return {~u16[15], u16[14:0]};
  endfunction

  logic [DIV_LOG2-1:0]   div_q, div_d;
  logic [1:0]            sync_l_q, sync_l_d, sync_r_q, sync_r_d;
  logic [2:0][W-1:0]     int_l_q, int_l_d, int_r_q, int_r_d;
  logic [2:0][W-1:0]     dly_l_q, dly_l_d, dly_r_q, dly_r_d;
  logic [2:0][W-1:0]     comb_l, comb_r;
  logic [DEC_LOG2-1:0]   dec_cnt_q, dec_cnt_d;
  logic [1:0]            discard_q, discard_d;
  logic                  load_q, load_d;
  logic [15:0]           pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [15:0]           adc_l_q, adc_l_d, adc_r_q, adc_r_d;
  logic                  valid_q, valid_d, overrun_q, overrun_d;
  logic                  tick, dec_tick;

  always_comb begin
    div_d    = div_q + 1'b1;
    tick     = &div_q;
    dec_tick = tick && (&dec_cnt_q);

    sync_l_d = {sync_l_q[0], pdm_L};
    sync_r_d = {sync_r_q[0], pdm_R};

    int_l_d = int_l_q;
    int_r_d = int_r_q;
    if (tick) begin
      int_l_d[0] = int_l_q[0] + {{(W-1){1'b0}}, sync_l_q[1]};
      int_l_d[1] = int_l_q[1] + int_l_q[0];
      int_l_d[2] = int_l_q[2] + int_l_q[1];
      int_r_d[0] = int_r_q[0] + {{(W-1){1'b0}}, sync_r_q[1]};
      int_r_d[1] = int_r_q[1] + int_r_q[0];
      int_r_d[2] = int_r_q[2] + int_r_q[1];
    end

    dec_cnt_d = tick ? dec_cnt_q + 1'b1 : dec_cnt_q;

    comb_l[0] = int_l_q[2] - dly_l_q[0];
    comb_l[1] = comb_l[0]  - dly_l_q[1];
    comb_l[2] = comb_l[1]  - dly_l_q[2];
    comb_r[0] = int_r_q[2] - dly_r_q[0];
    comb_r[1] = comb_r[0]  - dly_r_q[1];
    comb_r[2] = comb_r[1]  - dly_r_q[2];

    dly_l_d  = dec_tick ? {comb_l[1], comb_l[0], int_l_q[2]} : dly_l_q;
    dly_r_d  = dec_tick ? {comb_r[1], comb_r[0], int_r_q[2]} : dly_r_q;
    pend_l_d = dec_tick ? to_pcm(comb_l[2]) : pend_l_q;
    pend_r_d = dec_tick ? to_pcm(comb_r[2]) : pend_r_q;

    // The first three results carry the filter's start-up transient and are never presented.
    discard_d = (dec_tick && discard_q != 2'd3) ? discard_q + 2'd1 : discard_q;
    load_d    = dec_tick && (discard_q == 2'd3);

    adc_l_d   = adc_l_q;
    adc_r_d   = adc_r_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load_q) begin
      adc_l_d = pend_l_q;
      adc_r_d = pend_r_q;
      valid_d = 1'b1;
      if (rd_ack)       overrun_d = 1'b0;
      else if (valid_q) overrun_d = 1'b1;
    end else if (rd_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      sync_l_q  <= '0;
      sync_r_q  <= '0;
      int_l_q   <= '0;
      int_r_q   <= '0;
      dly_l_q   <= '0;
      dly_r_q   <= '0;
      dec_cnt_q <= '0;
      discard_q <= '0;
      load_q    <= 1'b0;
      pend_l_q  <= '0;
      pend_r_q  <= '0;
      adc_l_q   <= '0;
      adc_r_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      sync_l_q  <= sync_l_d;
      sync_r_q  <= sync_r_d;
      int_l_q   <= int_l_d;
      int_r_q   <= int_r_d;
      dly_l_q   <= dly_l_d;
      dly_r_q   <= dly_r_d;
      dec_cnt_q <= dec_cnt_d;
      discard_q <= discard_d;
      load_q    <= load_d;
      pend_l_q  <= pend_l_d;
      pend_r_q  <= pend_r_d;
      adc_l_q   <= adc_l_d;
      adc_r_q   <= adc_r_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign mod_clk     = div_q[DIV_LOG2-1];
  assign adc_L       = adc_l_q;
  assign adc_R       = adc_r_q;
  assign adc_valid   = valid_q;
  assign adc_overrun = overrun_q;

endmodule

// File: tb/tb_pdm_adc.sv
// tb/tb_pdm_adc.sv - Randomized pattern bench for pdm_adc with a density-based reference model.
module tb_pdm_adc;

  localparam int DIV_LOG2 = 5;
  localparam int DEC_LOG2 = 6;
  localparam int R        = 1 << DEC_LOG2;
  localparam int LOAD_GAP = 1 << (DIV_LOG2 + DEC_LOG2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pdm_L = 1'b0;
  logic        pdm_R = 1'b0;
  logic        rd_ack = 1'b0;
  logic        mod_clk;
  logic [15:0] adc_L, adc_R;
  logic        adc_valid, adc_overrun;

  int n_pass = 0;
  int n_total = 0;
  int since_rel = 0;
  logic [3:0] pat_l = 4'h0;
  logic [3:0] pat_r = 4'h0;
  logic [1:0] ph = 2'd0;

  pdm_adc #(.DIV_LOG2(DIV_LOG2), .DEC_LOG2(DEC_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .pdm_L(pdm_L), .pdm_R(pdm_R), .rd_ack(rd_ack),
    .mod_clk(mod_clk), .adc_L(adc_L), .adc_R(adc_R),
    .adc_valid(adc_valid), .adc_overrun(adc_overrun)
  );

  always #5 clk = ~clk;

  // External modulator: advances its periodic 4-bit pattern on each mod_clk rising edge.
  always @(posedge mod_clk) begin
    #1;
    ph = ph + 2'd1;
    pdm_L = pat_l[ph];
    pdm_R = pat_r[ph];
  end

  // A period-4 pattern has a fixed ones-count per R ticks, so the CIC settles to R^3 * density.
  function automatic logic [15:0] exp_sample(input logic [3:0] pat);
    longint u;
    logic [15:0] u16;
    u = longint'(R) * R * R * $countones(pat) / 4;
    if (u >= (longint'(1) << (3 * DEC_LOG2))) u16 = 16'hFFFF;
    else u16 = 16'(u >> (3 * DEC_LOG2 - 16));
    return {~u16[15], u16[14:0]};
  endfunction

  task automatic set_pattern(input logic [3:0] l, input logic [3:0] r);
    pat_l = l;
    pat_r = r;
    pdm_L = pat_l[ph];
    pdm_R = pat_r[ph];
  endtask

  task automatic wait_valid(input int limit, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (adc_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  task automatic run_loads(input int skip, input int chk, input string name);
    bit ok;
    int c;
    for (int i = 0; i < skip + chk; i++) begin
      wait_valid(LOAD_GAP + 200, ok, c);
      n_total++;
      if (!ok) $display("FAIL %s_timeout load %0d: adc_valid=%b after %0d cycles, want 1", name, i, adc_valid, c);
      else n_pass++;
      if (ok && i >= skip) begin
        n_total++;
        if (adc_L !== exp_sample(pat_l)) $display("FAIL %s_L got %h want %h", name, adc_L, exp_sample(pat_l));
        else n_pass++;
        n_total++;
        if (adc_R !== exp_sample(pat_r)) $display("FAIL %s_R got %h want %h", name, adc_R, exp_sample(pat_r));
        else n_pass++;
      end
      ack();
    end
  endtask

  task automatic test_reset();
    int t, r1, r2;
    logic prev;
    set_pattern(4'hF, 4'hF);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_total++; if (mod_clk !== 1'b0) $display("FAIL rst_mod_clk got %b want 0", mod_clk); else n_pass++;
    n_total++; if (adc_L !== 16'h0) $display("FAIL rst_adc_L got %h want 0000", adc_L); else n_pass++;
    n_total++; if (adc_R !== 16'h0) $display("FAIL rst_adc_R got %h want 0000", adc_R); else n_pass++;
    n_total++; if (adc_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", adc_valid); else n_pass++;
    n_total++; if (adc_overrun !== 1'b0) $display("FAIL rst_overrun got %b want 0", adc_overrun); else n_pass++;
    rst_n = 1'b1;
    t = 0; r1 = -1; r2 = -1;
    prev = mod_clk;
    for (int i = 0; i < 120 && r2 < 0; i++) begin
      @(negedge clk);
      t++;
      if (mod_clk && !prev) begin
        if (r1 < 0) r1 = t;
        else r2 = t;
      end
      prev = mod_clk;
    end
    since_rel = t;
    n_total++;
    if (r2 - r1 !== 32) $display("FAIL mod_clk_period got %0d want 32", r2 - r1);
    else n_pass++;
  endtask

  task automatic test_full_scale();
    bit ok;
    int c;
    wait_valid(5 * LOAD_GAP, ok, c);
    c += since_rel;
    n_total++;
    if (!ok || c < 4 * LOAD_GAP - 100 || c > 4 * LOAD_GAP + 100)
      $display("FAIL first_valid_latency got %0d cycles (valid=%b) want about %0d", c, adc_valid, 4 * LOAD_GAP);
    else n_pass++;
    n_total++; if (adc_L !== 16'h7FFF) $display("FAIL full_L got %h want 7fff", adc_L); else n_pass++;
    n_total++; if (adc_R !== 16'h7FFF) $display("FAIL full_R got %h want 7fff", adc_R); else n_pass++;
    ack();
    run_loads(0, 2, "full");
  endtask

  task automatic test_channels();
    set_pattern(4'h0, 4'hF);
    run_loads(3, 2, "chan");
  endtask

  task automatic test_density();
    set_pattern(4'b1010, 4'b1110);
    run_loads(3, 2, "dens");
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      set_pattern(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      run_loads(3, 1, "rand");
    end
  endtask

  task automatic test_handshake();
    bit ok;
    int c;
    wait_valid(LOAD_GAP + 200, ok, c);
    n_total++; if (!ok) $display("FAIL hs_timeout valid=%b want 1", adc_valid); else n_pass++;
    ack();
    n_total++; if (adc_valid !== 1'b0) $display("FAIL hs_ack_valid got %b want 0", adc_valid); else n_pass++;
    n_total++; if (adc_overrun !== 1'b0) $display("FAIL hs_ack_overrun got %b want 0", adc_overrun); else n_pass++;

    ack();
    n_total++; if (adc_valid !== 1'b0) $display("FAIL idle_ack_valid got %b want 0", adc_valid); else n_pass++;
    n_total++; if (adc_overrun !== 1'b0) $display("FAIL idle_ack_overrun got %b want 0", adc_overrun); else n_pass++;
    n_total++; if (adc_L !== exp_sample(pat_l)) $display("FAIL idle_ack_L got %h want %h", adc_L, exp_sample(pat_l)); else n_pass++;
    n_total++; if (adc_R !== exp_sample(pat_r)) $display("FAIL idle_ack_R got %h want %h", adc_R, exp_sample(pat_r)); else n_pass++;

    wait_valid(LOAD_GAP + 200, ok, c);
    repeat (LOAD_GAP + 50) @(negedge clk);
    n_total++; if (adc_valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", adc_valid); else n_pass++;
    n_total++; if (adc_overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", adc_overrun); else n_pass++;
    n_total++; if (adc_L !== exp_sample(pat_l)) $display("FAIL ovr_L got %h want %h", adc_L, exp_sample(pat_l)); else n_pass++;
    ack();
    n_total++; if (adc_valid !== 1'b0) $display("FAIL ovr_clear_valid got %b want 0", adc_valid); else n_pass++;
    n_total++; if (adc_overrun !== 1'b0) $display("FAIL ovr_clear_flag got %b want 0", adc_overrun); else n_pass++;

    // Leave one load unread, then ack exactly on the clock of the following load.
    wait_valid(LOAD_GAP + 200, ok, c);
    n_total++; if (!ok) $display("FAIL coin_timeout valid=%b want 1", adc_valid); else n_pass++;
    repeat (LOAD_GAP - 1) @(negedge clk);
    ack();
    n_total++; if (adc_valid !== 1'b1) $display("FAIL coin_valid got %b want 1", adc_valid); else n_pass++;
    n_total++; if (adc_overrun !== 1'b0) $display("FAIL coin_overrun got %b want 0", adc_overrun); else n_pass++;
    ack();
  endtask

  task automatic test_mid_reset();
    bit ok;
    int c;
    logic [3:0] l;
    wait_valid(LOAD_GAP + 200, ok, c);
    n_total++; if (!ok) $display("FAIL mrst_pre_valid got %b want 1", adc_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (adc_valid !== 1'b0) $display("FAIL mrst_valid got %b want 0", adc_valid); else n_pass++;
    n_total++; if (adc_L !== 16'h0 || adc_R !== 16'h0) $display("FAIL mrst_data got %h/%h want 0000/0000", adc_L, adc_R); else n_pass++;
    n_total++; if (mod_clk !== 1'b0 || adc_overrun !== 1'b0) $display("FAIL mrst_misc got mod_clk=%b overrun=%b want 0/0", mod_clk, adc_overrun); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    l = 4'($urandom_range(0, 15));
    set_pattern(l, ~l);
    wait_valid(5 * LOAD_GAP, ok, c);
    n_total++;
    if (!ok || c < 4 * LOAD_GAP - 100 || c > 4 * LOAD_GAP + 100)
      $display("FAIL mrst_latency got %0d cycles (valid=%b) want about %0d", c, adc_valid, 4 * LOAD_GAP);
    else n_pass++;
    n_total++; if (adc_L !== exp_sample(pat_l)) $display("FAIL mrst_L got %h want %h", adc_L, exp_sample(pat_l)); else n_pass++;
    n_total++; if (adc_R !== exp_sample(pat_r)) $display("FAIL mrst_R got %h want %h", adc_R, exp_sample(pat_r)); else n_pass++;
    ack();
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_channels();
    test_density();
    test_random();
    test_handshake();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
